// File: rtl/vga_line_fetcher.sv
// vga_line_fetcher
//   Feeds RGB565 pixels to the VGA signal generator from a double-buffered scanline
//   store. A fill engine fetches one line from video memory into the back buffer
//   over a req/ack interface; the display side streams the front buffer one pixel
//   per next_pixel strobe.
//
//   Optional build macro: VGA_LINE_FETCH_HDOUBLE_EN
//     defined   - horizontal pixel doubling: a fill fetches LINE_PIXELS/2 words and
//                 every fetched word is shown for two consecutive pixel strobes.
//     undefined - one fetched word per displayed pixel.
//
// Ports
//   pix_clk_i     pixel clock, all logic on the rising edge
//   reset_i       asynchronous active-high reset
//   next_frame_i  strobe: restart at line 0 of the frame and fetch it
//   next_line_i   strobe: fetch the following line
//   next_pixel_i  strobe: advance the display pixel
//   color_data_o  registered RGB565 pixel, valid the cycle after next_pixel_i
//   mem_req_o     memory read request
//   mem_addr_o    word address of the current request
//   mem_ack_i     memory returns mem_data_i for mem_addr_o this cycle
//   mem_data_i    read data, valid with mem_ack_i
//   underrun_o    sticky: a line started without a completed fill
//   overrun_o     sticky: a fill was aborted by a new strobe
module vga_line_fetcher #(
    parameter int unsigned        LINE_PIXELS    = 640,
    parameter int unsigned        ADDR_W         = 24,
    parameter logic [ADDR_W-1:0]  FB_BASE        = {ADDR_W{1'b0}},
    parameter int unsigned        LINE_STRIDE    = 640,
    parameter logic [15:0]        UNDERRUN_COLOR = 16'hF81F
) (
    input  logic              pix_clk_i,
    input  logic              reset_i,
    input  logic              next_frame_i,
    input  logic              next_line_i,
    input  logic              next_pixel_i,
    output logic [15:0]       color_data_o,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_ack_i,
    input  logic [15:0]       mem_data_i,
    output logic              underrun_o,
    output logic              overrun_o
);

`ifdef VGA_LINE_FETCH_HDOUBLE_EN
    localparam int unsigned FetchWords = LINE_PIXELS / 2;
`else
    localparam int unsigned FetchWords = LINE_PIXELS;
`endif
    localparam int unsigned IdxW     = (FetchWords > 1) ? $clog2(FetchWords) : 1;
    localparam int unsigned RamDepth = 2 * LINE_PIXELS;
    localparam int unsigned RamAw    = $clog2(RamDepth);

    localparam logic [IdxW-1:0]   LastIdx  = IdxW'(FetchWords - 1);
    localparam logic [ADDR_W-1:0] Stride   = ADDR_W'(LINE_STRIDE);
    localparam logic [RamAw-1:0]  BufOfs   = RamAw'(LINE_PIXELS);

    typedef enum logic [1:0] {StIdle, StFill, StDone} fill_state_e;

    fill_state_e       state_q, state_d;
    logic [ADDR_W-1:0] line_addr_q, line_addr_d;
    logic [IdxW-1:0]   wr_idx_q, wr_idx_d;
    logic [IdxW-1:0]   rd_idx_q, rd_idx_d;
    logic              back_valid_q, back_valid_d;
    logic              front_valid_q, front_valid_d;
    logic              front_sel_q, front_sel_d;
    logic              line_active_q, line_active_d;
    logic              underrun_q, underrun_d;
    logic              overrun_q, overrun_d;
    logic [15:0]       color_q;
`ifdef VGA_LINE_FETCH_HDOUBLE_EN
    logic              phase_q, phase_d;
`endif

    logic              strobe;
    logic              line_start;
    logic              ram_we;
    logic [RamAw-1:0]  wr_addr;
    logic [RamAw-1:0]  rd_addr;
    logic [15:0]       line_ram [RamDepth];

    assign strobe = next_frame_i | next_line_i;
    // A line strobe ends the current line in the same cycle, so a pixel arriving
    // alongside it already counts as the first pixel of the new line.
    assign line_start = next_pixel_i & (~line_active_q | strobe);

    always_comb begin
        state_d       = state_q;
        line_addr_d   = line_addr_q;
        wr_idx_d      = wr_idx_q;
        rd_idx_d      = rd_idx_q;
        back_valid_d  = back_valid_q;
        front_valid_d = front_valid_q;
        front_sel_d   = front_sel_q;
        line_active_d = line_active_q;
        underrun_d    = underrun_q;
        overrun_d     = overrun_q;
        ram_we        = 1'b0;
`ifdef VGA_LINE_FETCH_HDOUBLE_EN
        phase_d       = phase_q;
`endif

        // Clear first: an event in the same cycle as next_frame_i is still recorded.
        if (next_frame_i) begin
            underrun_d = 1'b0;
            overrun_d  = 1'b0;
        end

        // Display side. The swap is evaluated before the fill so that a fill
        // starting this cycle targets the new back buffer.
        if (strobe) begin
            line_active_d = 1'b0;
        end
        if (line_start) begin
            line_active_d = 1'b1;
            if (back_valid_q) begin
                front_sel_d   = ~front_sel_q;
                back_valid_d  = 1'b0;
                front_valid_d = 1'b1;
                rd_idx_d      = '0;
`ifdef VGA_LINE_FETCH_HDOUBLE_EN
                phase_d       = 1'b0;
`endif
            end else begin
                front_valid_d = 1'b0;
                underrun_d    = 1'b1;
            end
        end else if (next_pixel_i) begin
`ifdef VGA_LINE_FETCH_HDOUBLE_EN
            phase_d = ~phase_q;
            if (phase_q && (rd_idx_q != LastIdx)) begin
                rd_idx_d = rd_idx_q + 1'b1;
            end
`else
            if (rd_idx_q != LastIdx) begin
                rd_idx_d = rd_idx_q + 1'b1;
            end
`endif
        end

        // Fill engine
        unique case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (strobe) begin
                    state_d  = StFill;
                    wr_idx_d = '0;
                    if (next_frame_i) begin
                        line_addr_d = FB_BASE;
                    end
                end
            end
            StFill: begin
                if (strobe) begin
                    // Abort and restart; any ack this cycle belongs to the old fill.
                    overrun_d    = 1'b1;
                    back_valid_d = 1'b0;
                    wr_idx_d     = '0;
                    if (next_frame_i) begin
                        line_addr_d = FB_BASE;
                    end
                end else if (mem_ack_i) begin
                    ram_we = 1'b1;
                    if (wr_idx_q == LastIdx) begin
                        state_d      = StDone;
                        back_valid_d = 1'b1;
                        line_addr_d  = line_addr_q + Stride;
                        wr_idx_d     = '0;
                    end else begin
                        wr_idx_d = wr_idx_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Back buffer is the one not selected for display at the time of the write.
    assign wr_addr = front_sel_q ? RamAw'(wr_idx_q) : BufOfs + RamAw'(wr_idx_q);
    assign rd_addr = front_sel_d ? BufOfs + RamAw'(rd_idx_d) : RamAw'(rd_idx_d);

    always_ff @(posedge pix_clk_i) begin
        if (ram_we) begin
            line_ram[wr_addr] <= mem_data_i;
        end
    end

    always_ff @(posedge pix_clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q       <= StIdle;
            line_addr_q   <= FB_BASE;
            wr_idx_q      <= '0;
            rd_idx_q      <= '0;
            back_valid_q  <= 1'b0;
            front_valid_q <= 1'b0;
            front_sel_q   <= 1'b0;
            line_active_q <= 1'b0;
            underrun_q    <= 1'b0;
            overrun_q     <= 1'b0;
            color_q       <= 16'h0000;
`ifdef VGA_LINE_FETCH_HDOUBLE_EN
            phase_q       <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            line_addr_q   <= line_addr_d;
            wr_idx_q      <= wr_idx_d;
            rd_idx_q      <= rd_idx_d;
            back_valid_q  <= back_valid_d;
            front_valid_q <= front_valid_d;
            front_sel_q   <= front_sel_d;
            line_active_q <= line_active_d;
            underrun_q    <= underrun_d;
            overrun_q     <= overrun_d;
`ifdef VGA_LINE_FETCH_HDOUBLE_EN
            phase_q       <= phase_d;
`endif
            if (next_pixel_i) begin
                color_q <= front_valid_d ? line_ram[rd_addr] : UNDERRUN_COLOR;
            end
        end
    end

    assign mem_req_o    = (state_q == StFill);
    assign mem_addr_o   = line_addr_q + ADDR_W'(wr_idx_q);
    assign color_data_o = color_q;
    assign underrun_o   = underrun_q;
    assign overrun_o    = overrun_q;

endmodule

// File: tb/tb_vga_line_fetcher.sv
// Scoreboard bench for vga_line_fetcher. A line-level reference model predicts the
// address sequence of every fill and the pixel value of every next_pixel strobe;
// a memory responder and a pixel monitor pop those expectations independently.
module tb_vga_line_fetcher;

    localparam int unsigned LP     = 640;
    localparam int unsigned AW     = 24;
    localparam logic [23:0] BASE   = 24'h000000;
    localparam int unsigned STRIDE = 640;
    localparam logic [15:0] UCOL   = 16'hF81F;
`ifdef VGA_LINE_FETCH_HDOUBLE_EN
    localparam int WORDS = LP / 2;
`else
    localparam int WORDS = LP;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        nf = 1'b0, nl = 1'b0, np = 1'b0;
    logic [15:0] color;
    logic        req;
    logic [23:0] addr;
    logic        ack = 1'b0;
    logic [15:0] data = 16'h0;
    logic        und, ovr;

    vga_line_fetcher #(
        .LINE_PIXELS   (LP),
        .ADDR_W        (AW),
        .FB_BASE       (BASE),
        .LINE_STRIDE   (STRIDE),
        .UNDERRUN_COLOR(UCOL)
    ) dut (
        .pix_clk_i   (clk),
        .reset_i     (rst),
        .next_frame_i(nf),
        .next_line_i (nl),
        .next_pixel_i(np),
        .color_data_o(color),
        .mem_req_o   (req),
        .mem_addr_o  (addr),
        .mem_ack_i   (ack),
        .mem_data_i  (data),
        .underrun_o  (und),
        .overrun_o   (ovr)
    );

    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    logic [15:0] key;
    bit          mem_en = 1'b0;
    int unsigned ack_pct = 100;
    int          ack_cnt = 0;

    // Reference model: which frame line sits where.
    int cur_line = 0;   // next line a next_line strobe fetches
    int fill_line = 0;
    int back_line = 0;
    int front_line = 0;
    int pix_n = 0;      // pixels shown since line start
    bit filling = 0, back_v = 0, front_v = 0, active = 0;

    logic [23:0] exp_addr_q[$];
    logic [15:0] exp_pix_q[$];

    function automatic logic [23:0] line_base(input int line);
        return BASE + 24'(line * STRIDE);
    endfunction

    function automatic logic [15:0] pix_val(input int line, input int n);
        int          idx;
        logic [23:0] a;
`ifdef VGA_LINE_FETCH_HDOUBLE_EN
        idx = n / 2;
`else
        idx = n;
`endif
        if (idx > WORDS - 1) idx = WORDS - 1;
        a = line_base(line) + 24'(idx);
        return a[15:0] ^ key;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the DUT sampled the strobes.
    task automatic issue(input bit f, input bit l, input bit p);
        bit saved;
        saved = mem_en;
        if (f || l) begin
            mem_en = 1'b0;   // keep acks away from the strobe cycle
            @(posedge clk); #1;
        end
        nf = f; nl = l; np = p;
        if (p) begin
            if (!active || f || l) begin
                active = 1;
                if (back_v) begin
                    front_line = back_line; front_v = 1; back_v = 0; pix_n = 0;
                end else begin
                    front_v = 0;
                end
            end else begin
                pix_n++;
            end
            exp_pix_q.push_back(front_v ? pix_val(front_line, pix_n) : UCOL);
        end else if (f || l) begin
            active = 0;
        end
        if (f || l) begin
            if (filling) back_v = 0;
            if (f) cur_line = 0;
            fill_line = cur_line;
            filling = 1;
            ack_cnt = 0;
            exp_addr_q.delete();
            for (int i = 0; i < WORDS; i++) exp_addr_q.push_back(line_base(cur_line) + 24'(i));
        end
        @(posedge clk); #1;
        nf = 0; nl = 0; np = 0;
        mem_en = saved;
    endtask

    task automatic run_pixels(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            issue(0, 0, 1);
            repeat ($urandom_range(gap)) begin @(posedge clk); #1; end
        end
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while ((exp_addr_q.size() != 0 || req) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check({name, "_words_left"}, exp_addr_q.size(), 0);
        back_v = 1; back_line = fill_line; cur_line = fill_line + 1; filling = 0;
        @(negedge clk);
        check({name, "_req_low"}, req, 0);
        check({name, "_next_addr"}, addr, line_base(cur_line));
        @(posedge clk); #1;
    endtask

    task automatic wait_acks(input int target, input string name);
        int n;
        n = 0;
        while (ack_cnt < target && n < 5000) begin @(posedge clk); #1; n++; end
        tests++;
        if (n >= 5000) begin
            fails++;
            $display("FAIL %s: got %0d acks, expected %0d", name, ack_cnt, target);
        end
    endtask

    task automatic reset_model();
        active = 0; back_v = 0; front_v = 0; filling = 0; cur_line = 0; pix_n = 0;
        exp_addr_q.delete();
        exp_pix_q.delete();
    endtask

    task automatic check_reset(input string name);
        check({name, "_color"}, color, 0);
        check({name, "_req"}, req, 0);
        check({name, "_addr"}, addr, BASE);
        check({name, "_underrun"}, und, 0);
        check({name, "_overrun"}, ovr, 0);
    endtask

    // Memory responder: random ack, data derived from the requested address.
    initial begin
        forever begin
            @(negedge clk);
            ack = 1'b0;
            data = 16'($urandom);
            if (mem_en && !rst && req && ($urandom_range(99) < ack_pct)) begin
                if (exp_addr_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL mem_extra_req: got request at %0h, expected none", addr);
                end else begin
                    check("mem_addr", addr, exp_addr_q.pop_front());
                    ack = 1'b1;
                    data = addr[15:0] ^ key;
                    ack_cnt++;
                end
            end
        end
    end

    // Pixel monitor: one expectation per sampled next_pixel strobe.
    initial begin
        bit s;
        forever begin
            @(posedge clk);
            s = np;
            @(negedge clk);
            if (s && !rst) begin
                if (exp_pix_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL pixel_extra: got %0h, expected no pixel", color);
                end else begin
                    check("pixel", color, exp_pix_q.pop_front());
                end
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout, expected completion");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end

    initial begin
        key = 16'($urandom);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset("init");
        @(posedge clk); #1;
        rst = 1'b0;

        // Line start with nothing fetched: underrun colour and flag.
        issue(0, 0, 1);
        @(negedge clk);
        check("underrun_set", und, 1);
        check("overrun_quiet", ovr, 0);
        @(posedge clk); #1;
        issue(1, 0, 0);
        @(negedge clk);
        check("underrun_cleared", und, 0);
        check("frame_addr", addr, BASE);
        check("frame_req", req, 1);
        @(posedge clk); #1;

        // Line 0, ack every cycle, then display it.
        mem_en = 1'b1;
        ack_pct = 100;
        wait_done("line0");
        run_pixels(LP, 2);

        // Line 1 fetch, then display it (with saturation) while line 2 fetches.
        ack_pct = $urandom_range(90, 40);
        issue(0, 1, 0);
        wait_done("line1");
        issue(0, 1, 1);
        run_pixels(LP + 3, 2);
        wait_done("line2");

        // Abort the line 3 fill part way through.
        issue(0, 1, 1);
        wait_acks(300, "acks_before_abort");
        issue(0, 1, 0);
        @(negedge clk);
        check("overrun_set", ovr, 1);
        check("abort_restart_addr", addr, line_base(cur_line));
        check("abort_req", req, 1);
        @(posedge clk); #1;
        wait_done("line3_retry");
        run_pixels(12, 1);

        // Frame and line together: frame wins.
        issue(1, 1, 0);
        @(negedge clk);
        check("frame_line_addr", addr, BASE);
        check("frame_clears_overrun", ovr, 0);
        check("frame_clears_underrun", und, 0);
        @(posedge clk); #1;
        wait_done("frame_again");
        run_pixels(6, 0);

        // Reset in the middle of a fill that already saw an abort.
        issue(0, 1, 0);
        wait_acks(50, "acks_before_abort2");
        issue(0, 1, 0);
        wait_acks(100, "acks_before_reset");
        mem_en = 1'b0;
        rst = 1'b1;
        reset_model();
        @(negedge clk);
        check_reset("mid_fill_reset");
        @(posedge clk); #1;
        rst = 1'b0;
        issue(1, 0, 0);
        @(negedge clk);
        check("restart_addr", addr, BASE);
        @(posedge clk); #1;
        mem_en = 1'b1;
        wait_done("line0_after_reset");
        run_pixels(20, 1);

        repeat (3) @(negedge clk);
        check("pixels_outstanding", exp_pix_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
